mls_4_event_counter: RTL and testbench
======================================

MLS_4_EVENT_COUNTER -- requirements
Module: mls_4_event_counter

Interface
REQ-001 Parameter: WIDTH, 8, bit width of event counter.
REQ-002 Parameter: HOLD_LEN, 3, consecutive high samples of F that assert hold.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: f_in  input  1  F output of the upstream combinational stage F = ~(A&C)&D.
REQ-006 Port: en  input  1  count enable for rising-edge events.
REQ-007 Port: clr  input  1  synchronous counter/saturation clear.
REQ-008 Port: count  output  WIDTH  number of F rising edges counted.
REQ-009 Port: rise  output  1  one-cycle pulse per F rising edge.
REQ-010 Port: hold  output  1  F has been high for at least HOLD_LEN consecutive samples.
REQ-011 Port: sat  output  1  count has reached its all-ones value.

Function
REQ-012 The block SHALL sample f_in into register f_q on every clk rising edge.
REQ-013 rise SHALL be a register loaded with (f_in & ~f_q) on each edge: one-cycle pulse, 1-cycle latency after the sampled 0->1 transition.
REQ-014 A sustained f_in high SHALL produce exactly one rise pulse; a 1-cycle f_in pulse SHALL produce exactly one rise pulse.
REQ-015 Counter update priority per edge SHALL be: clr (count<=0, sat<=0) > increment > hold value.
REQ-016 Increment SHALL occur on the same edge that loads rise=1, only when en=1, clr=0 and count is not all-ones.
REQ-017 At count = 2^WIDTH-1 the counter SHALL saturate (no wrap), sat SHALL be 1 from the edge that loaded all-ones until clr or rst.
REQ-018 en and clr SHALL NOT affect f_q, rise, or the hold FSM.
REQ-019 Hold FSM states: IDLE, RUN, HELD; a run-length counter (width ceil(log2(HOLD_LEN+1))) tracks consecutive high samples.
REQ-020 IDLE: f_in=1 -> RUN with run=1 (or HELD directly if HOLD_LEN=1); f_in=0 -> stay.
REQ-021 RUN: f_in=0 -> IDLE, run=0; f_in=1 -> run+1, and -> HELD when run+1 = HOLD_LEN.
REQ-022 HELD: f_in=1 -> stay; f_in=0 -> IDLE, run=0.
REQ-023 hold SHALL be registered and equal 1 exactly while the FSM is in HELD.
REQ-024 Simultaneous clr and rise event SHALL yield count=0 (the event is dropped).
REQ-025 HOLD_LEN < 1 SHALL be illegal; behaviour unspecified.

Reset
REQ-026 rst=1 SHALL immediately, without a clock, force f_q=0, rise=0, count=0, sat=0, hold=0, run=0, FSM=IDLE.
REQ-027 Reset asserted mid-count or in HELD SHALL discard all state; after release, f_in already high SHALL produce one rise pulse on the first edge.

Structure
REQ-028 FSM state encodings (IDLE=2'd0, RUN=2'd1, HELD=2'd2) SHALL reside in the shared header mls_defs.vh and be included, not redefined locally.
REQ-029 The f_q register and rise generation SHALL be a sub-module named rise_detect (ports clk, rst, d, q, rise).
REQ-030 Counter and hold FSM SHALL reside in mls_4_event_counter; no latches, no combinational outputs.

Verification
REQ-031 Reset: rst pulsed asynchronously between edges -> all outputs 0 immediately, before next clk edge.
REQ-032 Edges: f_in pattern 0,1,1,0,1,0 (one value per cycle), en=1 -> rise pulses one cycle after each 0->1, count=2.
REQ-033 Hold: f_in high 2 cycles then low -> hold never 1; f_in high 4 cycles -> hold=1 from 3rd sampling edge for 2 cycles, then 0 one edge after f_in drops.
REQ-034 Saturation (WIDTH=4): 17 rising edges with en=1 -> count=15, sat=1; clr=1 one cycle -> count=0, sat=0.
REQ-035 Enable/clr: en=0 during 3 edges -> count unchanged, rise still pulses 3 times; clr coincident with rise -> count=0.
REQ-036 Upstream drive: A,C,D swept through 16 combinations into F=~(A&C)&D feeding f_in -> count equals number of 0->1 transitions of F.

Source files
------------

// File: rtl/mls_4_event_counter_pkg.sv
// Types and helpers shared by the event counter and its rise detector.
package mls_4_event_counter_pkg;

`include "mls_defs.vh"

    // Hold-detect FSM state; encodings come from the shared header so that
    // other blocks decoding the state agree with this one.
    typedef enum logic [1:0] {
        ST_IDLE = `MLS_ST_IDLE,
        ST_RUN  = `MLS_ST_RUN,
        ST_HELD = `MLS_ST_HELD
    } hold_state_t;

    // Width of the run-length counter: enough bits to hold HOLD_LEN itself.
    // HOLD_LEN below 1 is not a legal configuration; a 1-bit counter keeps
    // elaboration well formed in that case.
    function automatic int run_width(input int hold_len);
        if (hold_len < 1) begin
            return 1;
        end
        return (hold_len == 1) ? 1 : $clog2(hold_len + 1);
    endfunction

endpackage

// File: rtl/mls_4_event_counter_rise_detect.sv
// Samples the F signal and produces a registered one-cycle pulse on each
// sampled 0->1 transition.
import mls_4_event_counter_pkg::*;

module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic r_q;
    logic r_rise;

    // Delay line and edge pulse; reset clears the history so that an input
    // already high at release is seen as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_q    <= d;
            r_rise <= d & ~r_q;
        end
    end

    assign q    = r_q;
    assign rise = r_rise;

endmodule

// File: rtl/mls_defs.vh
// Shared encodings for the hold-detect FSM of the event counter.
`ifndef MLS_DEFS_VH
`define MLS_DEFS_VH

`define MLS_ST_IDLE 2'd0
`define MLS_ST_RUN  2'd1
`define MLS_ST_HELD 2'd2

`endif

// File: rtl/mls_4_event_counter.sv
// Event counter for the F = ~(A&C)&D stage: counts F rising edges with a
// saturating counter and flags F held high for HOLD_LEN samples.
//
// Hold FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | F sampled low (or just out of reset), run length is 0
//   RUN     | F sampled high for 1..HOLD_LEN-1 consecutive edges
//   HELD    | F sampled high for at least HOLD_LEN consecutive edges
import mls_4_event_counter_pkg::*;

module mls_4_event_counter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_in,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             rise,
    output logic             hold,
    output logic             sat
);

    localparam int               RUN_W      = run_width(HOLD_LEN);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(HOLD_LEN);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_PRE    = CNT_MAX - WIDTH'(1);

    logic             w_f_q;
    logic             w_rise;
    logic             w_rise_evt;
    logic             w_cnt_inc;
    logic [RUN_W-1:0] w_run_inc;

    logic [WIDTH-1:0] r_count;
    logic             r_sat;
    hold_state_t      r_state;
    logic [RUN_W-1:0] r_run;
    logic             r_hold;

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .d    (f_in),
        .q    (w_f_q),
        .rise (w_rise)
    );

    // The same term the detector registers into rise, so the increment lands
    // on the very edge that loads rise=1.
    assign w_rise_evt = f_in & ~w_f_q;
    assign w_cnt_inc  = w_rise_evt & en & (r_count != CNT_MAX);
    assign w_run_inc  = r_run + RUN_W'(1);

    // Saturating event counter: clear beats increment, increment beats hold.
    // A rise coinciding with clr is dropped rather than counted after clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_cnt_inc) begin
            r_count <= r_count + WIDTH'(1);
            if (r_count == CNT_PRE) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Hold-detect FSM with registered hold output; en/clr have no say here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_run   <= '0;
            r_hold  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (f_in) begin
                        r_run <= RUN_W'(1);
                        if (HOLD_LEN == 1) begin
                            r_state <= ST_HELD;
                            r_hold  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!f_in) begin
                        r_state <= ST_IDLE;
                        r_run   <= '0;
                        r_hold  <= 1'b0;
                    end else begin
                        r_run <= w_run_inc;
                        if (w_run_inc == RUN_TARGET) begin
                            r_state <= ST_HELD;
                            r_hold  <= 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!f_in) begin
                        r_state <= ST_IDLE;
                        r_run   <= '0;
                        r_hold  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_run   <= '0;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign rise  = w_rise;
    assign hold  = r_hold;
    assign sat   = r_sat;

endmodule

// File: tb/tb_mls_4_event_counter.sv
// Scoreboard bench for mls_4_event_counter (WIDTH=4, HOLD_LEN=3).
module tb_mls_4_event_counter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       f_in = 1'b0;
    logic       en   = 1'b0;
    logic       clr  = 1'b0;
    logic [3:0] count;
    logic       rise;
    logic       hold;
    logic       sat;

    int total = 0;
    int bad   = 0;

    // mask bits: [3] count, [2] rise, [1] hold, [0] sat
    typedef struct {
        string      tag;
        logic [3:0] mask;
        logic [3:0] c;
        logic       r;
        logic       h;
        logic       s;
    } exp_t;

    exp_t exp_q[$];

    mls_4_event_counter #(.WIDTH(4), .HOLD_LEN(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_in  (f_in),
        .en    (en),
        .clr   (clr),
        .count (count),
        .rise  (rise),
        .hold  (hold),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] m, input logic [3:0] c,
                        input logic r, input logic h, input logic s);
        exp_t e;
        e.tag  = tag;
        e.mask = m;
        e.c    = c;
        e.r    = r;
        e.h    = h;
        e.s    = s;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the
    // outputs must show after the following rising edge.
    task automatic step(input string tag, input logic f, input logic e, input logic cl,
                        input logic [3:0] m, input logic [3:0] c,
                        input logic r, input logic h, input logic s);
        @(negedge clk);
        f_in = f;
        en   = e;
        clr  = cl;
        push(tag, m, c, r, h, s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".count"}, count, 4'd0);
        chk({tag, ".rise"}, {3'b0, rise}, 4'd0);
        chk({tag, ".hold"}, {3'b0, hold}, 4'd0);
        chk({tag, ".sat"}, {3'b0, sat}, 4'd0);
    endtask

    // Monitor: one queued expectation is consumed just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[3]) chk({e.tag, ".count"}, count, e.c);
                if (e.mask[2]) chk({e.tag, ".rise"}, {3'b0, rise}, {3'b0, e.r});
                if (e.mask[1]) chk({e.tag, ".hold"}, {3'b0, hold}, {3'b0, e.h});
                if (e.mask[0]) chk({e.tag, ".sat"}, {3'b0, sat}, {3'b0, e.s});
            end
        end
    end

    initial begin
        #100000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic a, c, d, f;

        #1 rst = 1'b1;
        #1 chk_all_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Edge pattern 0,1,1,0,1,0
        step("edge0", 0, 1, 0, 4'hF, 4'd0, 0, 0, 0);
        step("edge1", 1, 1, 0, 4'hF, 4'd1, 1, 0, 0);
        step("edge2", 1, 1, 0, 4'hF, 4'd1, 0, 0, 0);
        step("edge3", 0, 1, 0, 4'hF, 4'd1, 0, 0, 0);
        step("edge4", 1, 1, 0, 4'hF, 4'd2, 1, 0, 0);
        step("edge5", 0, 1, 0, 4'hF, 4'd2, 0, 0, 0);

        // Two highs: hold must stay low
        step("hold2a", 1, 1, 0, 4'hF, 4'd3, 1, 0, 0);
        step("hold2b", 1, 1, 0, 4'hF, 4'd3, 0, 0, 0);
        step("hold2c", 0, 1, 0, 4'hF, 4'd3, 0, 0, 0);

        // Four highs: hold from 3rd sampling edge for 2 cycles
        step("hold4a", 1, 1, 0, 4'hF, 4'd4, 1, 0, 0);
        step("hold4b", 1, 1, 0, 4'hF, 4'd4, 0, 0, 0);
        step("hold4c", 1, 1, 0, 4'hF, 4'd4, 0, 1, 0);
        step("hold4d", 1, 1, 0, 4'hF, 4'd4, 0, 1, 0);
        step("hold4e", 0, 1, 0, 4'hF, 4'd4, 0, 0, 0);

        // en=0: rise still pulses, count frozen
        for (int k = 0; k < 3; k++) begin
            step("en0_hi", 1, 0, 0, 4'hF, 4'd4, 1, 0, 0);
            step("en0_lo", 0, 0, 0, 4'hF, 4'd4, 0, 0, 0);
        end

        // clr coincident with a rise: event dropped
        step("clr_rise", 1, 1, 1, 4'hF, 4'd0, 1, 0, 0);
        step("clr_rise_lo", 0, 1, 0, 4'hF, 4'd0, 0, 0, 0);

        // Saturation after 15 edges, 17 edges issued
        for (int k = 1; k <= 17; k++) begin
            step("sat_hi", 1, 1, 0, 4'hF, (k > 15) ? 4'd15 : 4'(k), 1, 0, (k >= 15));
            step("sat_lo", 0, 1, 0, 4'hF, (k > 15) ? 4'd15 : 4'(k), 0, 0, (k >= 15));
        end
        step("sat_clr", 0, 1, 1, 4'hF, 4'd0, 0, 0, 0);
        step("sat_after", 0, 1, 0, 4'hF, 4'd0, 0, 0, 0);

        // Upstream sweep: A=i[3], C=i[1], D=i[0]; F has 6 rising edges
        for (int i = 0; i < 16; i++) begin
            a = i[3];
            c = i[1];
            d = i[0];
            f = ~(a & c) & d;
            step("sweep", f, 1, 0, 4'b0010, 4'd0, 0, 0, 0);
        end
        step("sweep_end", 0, 1, 0, 4'hF, 4'd6, 0, 0, 0);

        // Reach HELD, then asynchronous reset between edges
        step("pre_rst_a", 1, 1, 0, 4'hF, 4'd7, 1, 0, 0);
        step("pre_rst_b", 1, 1, 0, 4'hF, 4'd7, 0, 0, 0);
        step("pre_rst_c", 1, 1, 0, 4'hF, 4'd7, 0, 1, 0);
        drain();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");

        // Release with F already high: one rise on the first edge
        @(negedge clk);
        rst  = 1'b0;
        f_in = 1'b1;
        en   = 1'b1;
        clr  = 1'b0;
        push("rel1", 4'hF, 4'd1, 1, 0, 0);
        step("rel2", 1, 1, 0, 4'hF, 4'd1, 0, 0, 0);
        step("rel3", 1, 1, 0, 4'hF, 4'd1, 0, 1, 0);
        step("rel4", 0, 1, 0, 4'hF, 4'd1, 0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
